// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared definitions for the load/store unit:
//   - RV32I funct3 codes for loads and stores
//   - datamem access-size encoding driven on dmem_sel
//   - FSM state encoding
//   - small helpers for legality, alignment and access size
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

  // RV32I funct3 codes. Stores reuse the B/H/W codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    SEL_BYTE = 3'd0,
    SEL_HALF = 3'd1,
    SEL_WORD = 3'd2
  } dmem_sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Stores only have signed-width codes; loads add the unsigned variants.
  function automatic logic funct3_legal(input logic is_write, input logic [2:0] f3);
    if (is_write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes the access size for every legal code.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~addr_lo[0];
      default: return addr_lo == 2'b00;
    endcase
  endfunction

  function automatic dmem_sel_e size_sel(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SEL_BYTE;
      2'b01:   return SEL_HALF;
      default: return SEL_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Turns the right-justified assembled load data into the architectural
//   result: sign-extend for LB/LH, zero-extend for LBU/LHU, pass LW through.
//   Any other funct3 yields zero.
//   Ports:
//     asm_data  in  32  assembled load data, right-justified
//     funct3    in   3  RV32I load funct3
//     rdata     out 32  extended result
// -----------------------------------------------------------------------------
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] asm_data,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{asm_data[7]}}, asm_data[7:0]};
      F3_H:    rdata = {{16{asm_data[15]}}, asm_data[15:0]};
      F3_W:    rdata = asm_data;
      F3_BU:   rdata = {24'd0, asm_data[7:0]};
      F3_HU:   rdata = {16'd0, asm_data[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Single-outstanding RV32I load/store unit in front of a one-cycle-latency
//   data memory. Aligned accesses use one beat at their natural size;
//   misaligned halves/words are split into 2/4 byte beats. Illegal funct3 or
//   out-of-range addresses fault without touching memory.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     req_valid/req_ready               request handshake (ready only in IDLE)
//     req_write, req_funct3, req_addr,
//     req_wdata                         request fields
//     resp_valid/resp_ready             response handshake
//     resp_rdata, resp_fault, resp_split response fields
//     dmem_addr, dmem_data, dmem_sel,
//     dmem_write, dmem_out              datamem port
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              resp_split,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_data,
  output logic [2:0]        dmem_sel,
  output logic              dmem_write,
  input  logic [31:0]       dmem_out
);

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         beat_q, beat_d;
  logic               split_q, split_d;
  logic [31:0]        asm_q, asm_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_fault_q, resp_fault_d;
  logic               resp_split_q, resp_split_d;

  logic               req_fault;
  logic [1:0]         last_beat;
  logic [31:0]        ext_rdata;

  assign req_fault = !funct3_legal(req_write, req_funct3) ||
                     ((req_addr >> ADDR_W) != 32'd0);

  // Split halves take two byte beats, split words four.
  always_comb begin
    last_beat = 2'd0;
    if (split_q) last_beat = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  end

  // Load assembly lives in its own process so the extender can see the
  // final beat's byte in the same cycle without a combinational loop
  // through the FSM block.
  always_comb begin
    asm_d = asm_q;
    if (state_q == IDLE) begin
      asm_d = '0;
    end else if (state_q == CAPTURE && !write_q) begin
      if (split_q) asm_d[{beat_q, 3'b000} +: 8] = dmem_out[7:0];
      else         asm_d = dmem_out;
    end
  end

  load_extend u_load_extend (
    .asm_data (asm_d),
    .funct3   (funct3_q),
    .rdata    (ext_rdata)
  );

  // NOTE: every signal written here gets its hold value first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    split_d      = split_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    resp_split_d = resp_split_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr[ADDR_W-1:0];
          wdata_d  = req_wdata;
          beat_d   = 2'd0;
          split_d  = !is_aligned(req_funct3, req_addr[1:0]);
          if (req_fault) begin
            resp_rdata_d = '0;
            resp_fault_d = 1'b1;
            resp_split_d = 1'b0;
            state_d      = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        if (beat_q == last_beat) begin
          resp_rdata_d = write_q ? 32'd0 : ext_rdata;
          resp_fault_d = 1'b0;
          resp_split_d = split_q;
          state_d      = RESP;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = ISSUE;
        end
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= 2'd0;
      split_q      <= 1'b0;
      asm_q        <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      resp_split_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      split_q      <= split_d;
      asm_q        <= asm_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      resp_split_q <= resp_split_d;
    end
  end

  // rst gates ready and write directly so a reset landing mid-ISSUE cannot
  // complete the pending store beat.
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign resp_split = resp_split_q;

  assign dmem_addr  = addr_q + ADDR_W'(beat_q);
  assign dmem_sel   = split_q ? SEL_BYTE : size_sel(funct3_q);
  assign dmem_data  = split_q ? (wdata_q >> {beat_q, 3'b000}) : wdata_q;
  assign dmem_write = (state_q == ISSUE) && write_q && !rst;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, datamem byte-address width.
REQ-002 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  out  1  LSU can accept a request.
REQ-006 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  in  3  RV32I funct3: LB/LH/LW/LBU/LHU (000/001/010/100/101), SB/SH/SW (000/001/010).
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-010 SHALL have port resp_valid  out  1  response available.
REQ-011 SHALL have port resp_ready  in  1  pipeline consumes response.
REQ-012 SHALL have port resp_rdata  out  32  extended load result; 0 for stores and faults.
REQ-013 SHALL have port resp_fault  out  1  illegal funct3 or address above ADDR_W range.
REQ-014 SHALL have port resp_split  out  1  access was misaligned and split into byte beats.
REQ-015 SHALL have ports dmem_addr out ADDR_W, dmem_data out 32, dmem_sel out 3 (0 byte, 1 half, 2 word), dmem_write out 1, dmem_out in 32: datamem port.

Function
REQ-016 SHALL use FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-017 SHALL assert req_ready only in IDLE; request accepted on edge with req_valid && req_ready, capturing all req_* fields.
REQ-018 SHALL fault without any dmem access when funct3 is illegal for the direction or req_addr[31:ADDR_W] != 0: IDLE -> RESP directly, resp_fault=1.
REQ-019 SHALL classify aligned: byte always; half if addr[0]=0; word if addr[1:0]=0. Aligned = 1 beat with dmem_sel per size; misaligned = N byte beats (half N=2, word N=4), dmem_sel=0.
REQ-020 SHALL, in ISSUE for beat k, drive dmem_addr = addr+k (wraps modulo 2^ADDR_W), dmem_data = wdata >> 8k (aligned: wdata), dmem_write = req_write; next state CAPTURE.
REQ-021 SHALL hold dmem_write=0 in every state except ISSUE of a store.
REQ-022 SHALL treat datamem read latency as one cycle: in CAPTURE, dmem_out holds the addressed datum right-justified; for loads, beat k byte dmem_out[7:0] goes to assembly bits [8k+7:8k] (aligned: whole dmem_out).
REQ-023 SHALL go CAPTURE -> ISSUE with k+1 if beats remain, else -> RESP.
REQ-024 SHALL sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW, in resp_rdata.
REQ-025 SHALL hold resp_valid=1 and resp_* stable in RESP until resp_ready=1, then -> IDLE; no new request accepted in that same cycle.
REQ-026 SHALL give response latency: resp_valid first high 1+2N cycles after accepting edge (N=1 aligned), 1 cycle for faults.

Reset
REQ-027 SHALL on rst: state IDLE, k=0, resp_valid=0, resp_rdata=0, resp_fault=0, resp_split=0, req_ready=0 during reset cycle, 1 after.
REQ-028 SHALL force dmem_write=0 combinationally whenever rst=1, including mid-ISSUE; an aborted split store may leave earlier bytes written.

Structure
REQ-029 SHALL place funct3 codes, dmem_sel encodings and FSM state encodings in a shared package/include.
REQ-030 SHALL implement extension/alignment as sub-module load_extend (assembled data, funct3 -> resp_rdata).

Verification
REQ-031 SHALL test SW addr 8, wdata 0xDEADBEEF then LW addr 8 -> one beat each, dmem_sel=2, resp_rdata=0xDEADBEEF at cycle 3.
REQ-032 SHALL test SB 0x80 to addr 3, then LB addr 3 -> 0xFFFFFF80; LBU addr 3 -> 0x00000080.
REQ-033 SHALL test SW addr 5, wdata 0x11223344 -> four byte writes at 5,6,7,8 with data 0x44,0x33,0x22,0x11, resp_split=1; LW addr 5 -> 0x11223344 at cycle 9.
REQ-034 SHALL test LH addr 0xFFF (ADDR_W=12) -> beats at 0xFFF then 0x000 (wrap); load funct3=011 and addr 0x1000 -> resp_fault=1, no dmem_write, resp at cycle 1.
REQ-035 SHALL test rst asserted during beat 2 of split SW -> dmem_write=0 that cycle, IDLE next, resp_valid never asserted; resp_ready held low 5 cycles -> response stable, req_ready=0.
